// File: rtl/bp_fe_pkg.sv
// Front-end branch predictor shared definitions.
//
// Contents:
//   bp_fe_bht_state_e : BHT controller state (init sweep, ready).
//   bht_init_ctr()    : weakly-not-taken reset value for a counter of the given
//                       width, i.e. the largest value whose MSB is still clear.
package bp_fe_pkg;

  typedef enum logic {
    eINIT,
    eREADY
  } bp_fe_bht_state_e;

  // 2**(w-1)-1: just below the taken threshold, so a single taken
  // outcome flips the prediction.
  function automatic int unsigned bht_init_ctr(input int unsigned ctr_width);
    return (32'd1 << (ctr_width - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_fe_bht_sat_ctr.sv
// Combinational saturating up/down counter step used on the BHT update path.
//
// Ports:
//   ctr      in  ctr_width_p  current counter value
//   taken    in  1            resolved branch outcome (1 = count up)
//   ctr_next out ctr_width_p  updated counter; holds at all-ones / all-zeros
module bp_fe_bht_sat_ctr #(
  parameter int ctr_width_p = 2
) (
  input  logic [ctr_width_p-1:0] ctr,
  input  logic                   taken,
  output logic [ctr_width_p-1:0] ctr_next
);

  localparam logic [ctr_width_p-1:0] one_lp = ctr_width_p'(1);

  // Step toward the outcome, but never wrap past either end so a strongly
  // biased branch stays strongly biased.
  always_comb begin
    ctr_next = ctr;
    if (taken && (ctr != '1)) begin
      ctr_next = ctr + one_lp;
    end else if (!taken && (ctr != '0)) begin
      ctr_next = ctr - one_lp;
    end
  end

endmodule

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table for the front end.
//
// An array of ctr_width_p-bit saturating counters is indexed by the PC index
// XORed with a global history register (GHR). Reads are registered (result one
// cycle after the request); each prediction returns the GHR it used so the
// later update can rebuild the same index. After reset the array is swept to
// weakly-not-taken, one entry per cycle, so it can be mapped onto an SRAM with
// no reset of its own.
//
// Optional feature macro: BP_FE_BHT_GSHARE_HASH_EN
//   defined   : index = idx ^ zero-extended ghist (gshare)
//   undefined : index = idx (bimodal); the GHR is still kept and reported
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   init_done_o            high once the init sweep has finished
//   r_v_i, r_idx_i         read request and PC-derived index
//   predict_v_o            one-cycle pulse, prediction valid
//   predict_o              predicted taken (counter MSB)
//   predict_strong_o       counter saturated at either end
//   predict_ghist_o        GHR used for this read's hash
//   w_v_i, w_idx_i         update request and PC-derived index
//   w_ghist_i              predict_ghist_o captured at prediction time
//   w_taken_i              actual branch outcome
module bp_fe_bht_gshare
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int ctr_width_p     = 2,
  parameter int ghist_width_p   = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,

  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic                       predict_strong_o,
  output logic [ghist_width_p-1:0]   predict_ghist_o,

  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i
);

  localparam int els_lp = 1 << bht_idx_width_p;
  localparam logic [bht_idx_width_p-1:0] last_idx_lp = '1;
  localparam logic [bht_idx_width_p-1:0] ptr_one_lp  = bht_idx_width_p'(1);
  localparam logic [ctr_width_p-1:0]     init_ctr_lp = ctr_width_p'(bht_init_ctr(ctr_width_p));

  bp_fe_bht_state_e           state;
  logic [bht_idx_width_p-1:0] ptr;
  logic [ghist_width_p-1:0]   ghr;
  logic [ctr_width_p-1:0]     ctr_mem [els_lp];

  logic                       ready;
  logic [bht_idx_width_p-1:0] r_hash;
  logic [bht_idx_width_p-1:0] w_hash;
  logic [ctr_width_p-1:0]     r_ctr;
  logic [ctr_width_p-1:0]     w_ctr;
  logic [ctr_width_p-1:0]     w_ctr_next;
  logic                       r_fire;

  assign ready       = (state == eREADY);
  assign init_done_o = ready;
  assign r_fire      = ready & r_v_i;

`ifdef BP_FE_BHT_GSHARE_HASH_EN
  // History sits in the low index bits; the cast zero-extends it.
  assign r_hash = r_idx_i ^ bht_idx_width_p'(ghr);
  assign w_hash = w_idx_i ^ bht_idx_width_p'(w_ghist_i);
`else
  // Bimodal indexing: the update-side history snapshot has no role.
  logic unused_w_ghist;
  assign unused_w_ghist = ^w_ghist_i;
  assign r_hash = r_idx_i;
  assign w_hash = w_idx_i;
`endif

  assign r_ctr = ctr_mem[r_hash];
  assign w_ctr = ctr_mem[w_hash];

  bp_fe_bht_sat_ctr #(
    .ctr_width_p(ctr_width_p)
  ) u_sat_ctr (
    .ctr      (w_ctr),
    .taken    (w_taken_i),
    .ctr_next (w_ctr_next)
  );

  // Controller: sweep pointer walks every entry once, then the table is
  // ready for good. The GHR only shifts on accepted updates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= eINIT;
      ptr   <= '0;
      ghr   <= '0;
    end else if (state == eINIT) begin
      ptr <= ptr + ptr_one_lp;
      if (ptr == last_idx_lp) begin
        state <= eREADY;
      end
    end else if (w_v_i) begin
      ghr <= (ghr << 1) | ghist_width_p'(w_taken_i);
    end
  end

  // Counter array has no reset so it can become an SRAM; the sweep port
  // and the update port are never active in the same state.
  always_ff @(posedge clk_i) begin
    if (state == eINIT) begin
      ctr_mem[ptr] <= init_ctr_lp;
    end else if (w_v_i) begin
      ctr_mem[w_hash] <= w_ctr_next;
    end
  end

  // Registered read. Sampling with the pre-edge array and GHR gives
  // read-before-write when a same-cycle update hits the same entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      predict_v_o      <= 1'b0;
      predict_o        <= 1'b0;
      predict_strong_o <= 1'b0;
      predict_ghist_o  <= '0;
    end else begin
      predict_v_o <= r_fire;
      if (r_fire) begin
        predict_o        <= r_ctr[ctr_width_p-1];
        predict_strong_o <= (r_ctr == '0) || (r_ctr == '1);
        predict_ghist_o  <= ghr;
      end
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Self-checking bench for bp_fe_bht_gshare at 16 entries, 2-bit counters,
// 2-bit history. Directed table vectors, randomized traffic against a
// behavioural model, and reset/init-sweep timing checks.
module tb_bp_fe_bht_gshare;

  localparam int idx_w   = 4;
  localparam int ctr_w   = 2;
  localparam int gh_w    = 2;
  localparam int els     = 1 << idx_w;
  localparam int ctr_max = (1 << ctr_w) - 1;
  localparam int ctr_ini = (1 << (ctr_w - 1)) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             init_done;
  logic             r_v = 1'b0;
  logic [idx_w-1:0] r_idx = '0;
  logic             predict_v;
  logic             predict;
  logic             predict_strong;
  logic [gh_w-1:0]  predict_ghist;
  logic             w_v = 1'b0;
  logic [idx_w-1:0] w_idx = '0;
  logic [gh_w-1:0]  w_ghist = '0;
  logic             w_taken = 1'b0;

  bp_fe_bht_gshare #(
    .bht_idx_width_p (idx_w),
    .ctr_width_p     (ctr_w),
    .ghist_width_p   (gh_w)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .init_done_o      (init_done),
    .r_v_i            (r_v),
    .r_idx_i          (r_idx),
    .predict_v_o      (predict_v),
    .predict_o        (predict),
    .predict_strong_o (predict_strong),
    .predict_ghist_o  (predict_ghist),
    .w_v_i            (w_v),
    .w_idx_i          (w_idx),
    .w_ghist_i        (w_ghist),
    .w_taken_i        (w_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r_v; int r_idx; int w_v; int w_idx; int w_ghist; int w_taken;
    int e_v; int e_p; int e_s; int e_g;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad = 0;

  // Behavioural model: counters as plain integers, history as an integer.
  int m_ctr [els];
  int m_ghr;
  int e_v, e_p, e_s, e_g;

  function automatic int hash(input int idx, input int gh);
`ifdef BP_FE_BHT_GSHARE_HASH_EN
    return idx ^ gh;
`else
    return idx + 0 * gh;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < els; i++) m_ctr[i] = ctr_ini;
    m_ghr = 0;
    e_v = 0; e_p = 0; e_s = 0; e_g = 0;
  endfunction

  function automatic void add_vec(input int rv, input int ri, input int wv, input int wi,
                                  input int wg, input int wt,
                                  input int ev, input int ep, input int es, input int eg);
    vec_t v;
    v.r_v = rv; v.r_idx = ri; v.w_v = wv; v.w_idx = wi; v.w_ghist = wg; v.w_taken = wt;
    v.e_v = ev; v.e_p = ep; v.e_s = es; v.e_g = eg;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int ev, input int ep, input int es, input int eg);
    compare($sformatf("%s predict_v", tag), 32'(predict_v), ev);
    compare($sformatf("%s predict", tag), 32'(predict), ep);
    compare($sformatf("%s strong", tag), 32'(predict_strong), es);
    compare($sformatf("%s ghist", tag), 32'(predict_ghist), eg);
  endtask

  // Drive one cycle of traffic and advance the model by the same cycle:
  // the read sees pre-update counters and history, then the write lands.
  task automatic applyStimulus(input int rv, input int ri, input int wv, input int wi,
                               input int wg, input int wt);
    int h;
    r_v = rv[0]; r_idx = idx_w'(ri);
    w_v = wv[0]; w_idx = idx_w'(wi); w_ghist = gh_w'(wg); w_taken = wt[0];
    tick();
    r_v = 1'b0; w_v = 1'b0;
    if (rv != 0) begin
      h = hash(ri, m_ghr);
      e_v = 1;
      e_p = (m_ctr[h] > ctr_ini) ? 1 : 0;
      e_s = (m_ctr[h] == 0 || m_ctr[h] == ctr_max) ? 1 : 0;
      e_g = m_ghr;
    end else begin
      e_v = 0;
    end
    if (wv != 0) begin
      h = hash(wi, wg);
      if (wt != 0) m_ctr[h] = (m_ctr[h] + 1 > ctr_max) ? ctr_max : m_ctr[h] + 1;
      else         m_ctr[h] = (m_ctr[h] - 1 < 0) ? 0 : m_ctr[h] - 1;
      m_ghr = (m_ghr * 2 + (wt != 0 ? 1 : 0)) % (1 << gh_w);
    end
  endtask

  // Hold a read request through the sweep; it must never be answered.
  task automatic wait_init(input string name);
    int cycles = 0;
    int seen_pred = 0;
    r_v = 1'b1; r_idx = 4'd5;
    while (!init_done && cycles < 64) begin
      tick();
      cycles++;
      if (predict_v) seen_pred = 1;
    end
    r_v = 1'b0;
    compare($sformatf("%s cycles", name), cycles, 16);
    compare($sformatf("%s no predict during sweep", name), seen_pred, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hp, hs;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0);
    compare("reset init_done", 32'(init_done), 0);
    tick();
    reset = 1'b0;
    wait_init("init1");
    model_reset();

    // Directed table. Fresh table: every read is weakly not-taken.
    for (int i = 0; i < els; i++) add_vec(1, i, 0, 0, 0, 0, 1, 0, 0, 0);
    // Train entry 3 taken three times: 01->10->11->11
    for (int i = 0; i < 3; i++) add_vec(0, 0, 1, 3, 0, 1, 0, 0, 0, 0);
    // Two not-taken updates to 12 bring GHR to 0 and saturate 12 low
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 12, 0, 0, 0, 0, 0, 0);
    add_vec(1, 3, 0, 0, 0, 0, 1, 1, 1, 0);
    add_vec(1, 12, 0, 0, 0, 0, 1, 0, 1, 0);
    // Pre-train entry 7 to 11, clear GHR, then GHR 00->01->10
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 7, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 12, 0, 0, 0, 0, 1, 0);
    add_vec(0, 0, 1, 13, 0, 1, 0, 0, 1, 0);
    add_vec(0, 0, 1, 13, 0, 0, 0, 0, 1, 0);
`ifdef BP_FE_BHT_GSHARE_HASH_EN
    hp = 1; hs = 1;
`else
    hp = 0; hs = 0;
`endif
    add_vec(1, 5, 0, 0, 0, 0, 1, hp, hs, 2);
    // Read idx 0 under GHR=2 while clearing GHR; entries 0 and 2 untouched
    add_vec(1, 0, 1, 12, 0, 0, 1, 0, 0, 2);
    add_vec(0, 0, 1, 12, 0, 0, 0, 0, 0, 2);
    // Same-cycle read/write of entry 4: read sees the old counter
    add_vec(1, 4, 1, 4, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 12, 0, 0, 0, 0, 0, 0);
    add_vec(1, 4, 0, 0, 0, 0, 1, 1, 0, 0);
`ifndef BP_FE_BHT_GSHARE_HASH_EN
    // Bimodal: entry 5 trained to 11 predicts taken under any GHR
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 5, 3, 1, 0, 1, 0, 0);
    add_vec(1, 5, 0, 0, 0, 0, 1, 1, 1, 3);
    for (int i = 0; i < 2; i++) add_vec(0, 0, 1, 12, 0, 0, 0, 1, 1, 3);
    add_vec(1, 5, 0, 0, 0, 0, 1, 1, 1, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r_v, vecs[i].r_idx, vecs[i].w_v, vecs[i].w_idx,
                    vecs[i].w_ghist, vecs[i].w_taken);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_p, vecs[i].e_s, vecs[i].e_g);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int wg;
      wg = ($urandom_range(0, 1) == 1) ? m_ghr : int'($urandom_range(0, 3));
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, els - 1)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, els - 1)),
                    wg, int'($urandom_range(0, 1)));
      checkOutput($sformatf("rnd%0d", i), e_v, e_p, e_s, e_g);
    end

    // Asynchronous reset from ready, away from any clock edge
    compare("ready before reset", 32'(init_done), 1);
    #2 reset = 1'b1;
    #1;
    compare("async reset init_done", 32'(init_done), 0);
    checkOutput("async reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    // Seven sweep edges leave the pointer at 7, then reset again
    repeat (7) tick();
    compare("mid sweep init_done", 32'(init_done), 0);
    #2 reset = 1'b1;
    #1;
    compare("mid sweep reset init_done", 32'(init_done), 0);
    checkOutput("mid sweep reset", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    wait_init("init2");
    model_reset();
    for (int i = 0; i < els; i++) begin
      applyStimulus(1, i, 0, 0, 0, 0);
      checkOutput($sformatf("reinit%0d", i), e_v, e_p, e_s, e_g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_gshare.md
Name: bp_fe_bht_gshare

Overview:
- Parametrised gshare branch history table for the front end; next generation of the fixed 2-bit, 2-history-bit BHT.
- Predicts direction from an array of N-bit saturating counters indexed by the PC index XORed with a global history register (GHR).
- Has a registered 1-cycle read, a history snapshot returned with each prediction for use at update, a confidence output, and a post-reset init sweep so the array can later map to SRAM.

Parameters:
- bht_idx_width_p, 9, log2 of counter entries; els = 2**bht_idx_width_p.
- ctr_width_p, 2, saturating counter width (>=2).
- ghist_width_p, 8, GHR width; must be <= bht_idx_width_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- init_done_o  out  1  high once init sweep complete
- r_v_i  in  1  read request
- r_idx_i  in  bht_idx_width_p  PC-derived read index
- predict_v_o  out  1  prediction valid (1 cycle after accepted read)
- predict_o  out  1  predicted taken (counter MSB)
- predict_strong_o  out  1  counter saturated (all-ones or all-zeros)
- predict_ghist_o  out  ghist_width_p  GHR value used for this read's hash
- w_v_i  in  1  update request (branch resolved)
- w_idx_i  in  bht_idx_width_p  PC-derived index of resolved branch
- w_ghist_i  in  ghist_width_p  predict_ghist_o captured at prediction time
- w_taken_i  in  1  actual branch outcome

Behaviour:
- Reset (async): state=eINIT, sweep ptr=0, GHR=0, predict_v_o=0, predict_o=0, predict_strong_o=0, predict_ghist_o=0, init_done_o=0.
- FSM:
  - eINIT: one entry per cycle is written to 2**(ctr_width_p-1)-1 (weakly not-taken; 2'b01 at default). ptr increments.
  - After ptr==els-1 is written: go to eREADY, init_done_o=1 next cycle. Init takes exactly els cycles.
  - eREADY: terminal until reset.
- Reset asserted mid-sweep or mid-operation: immediately returns to eINIT with ptr=0; the sweep restarts from scratch.
- During eINIT: r_v_i and w_v_i are ignored. No prediction, no GHR shift, no counter change.
- Hash: h = idx ^ {zero-pad, ghist}, with ghist right-aligned in the low bits.
  - Read uses the current GHR.
  - Write uses w_ghist_i.
- Read, eREADY and r_v_i in cycle t, at t+1:
  - predict_v_o=1
  - predict_o=ctr[h][MSB]
  - predict_strong_o=(ctr==0 || ctr==max)
  - predict_ghist_o = GHR as sampled at t
- Prediction outputs hold their values until the next accepted read; predict_v_o is a 1-cycle pulse.
- Write, eREADY and w_v_i at edge:
  - Counter update: taken -> ctr = min(ctr+1, max); not-taken -> ctr = max(ctr-1, 0). No wrap at either end.
  - GHR <= {GHR[ghist_width_p-2:0], w_taken_i}.
- Same-cycle read and write:
  - Read samples the counter and GHR before the update (read-before-write), even when both hash to the same entry.
  - The write commits.
- Back-to-back reads are accepted every cycle. There is no backpressure.

Optional Feature:
- BP_FE_BHT_GSHARE_HASH_EN
  - Defined: XOR hashing as above.
  - Undefined: h = idx (pure bimodal). The GHR is still maintained and reported on predict_ghist_o, but the read and write indices ignore it.

Decomposition:
- bp_fe_pkg gains:
  - bp_fe_bht_state_e enum {eINIT, eREADY}
  - a function computing the weakly-not-taken init constant from ctr_width_p
- One sub-module, bp_fe_bht_sat_ctr: combinational saturating up/down counter step, parameter ctr_width_p, inputs ctr and taken.
- Array, GHR and FSM stay in the top.

Test Plan:
All at bht_idx_width_p=4, ctr_width_p=2, ghist_width_p=2, hash enabled.
- Release reset, poll init_done_o:
  - Rises exactly 16 cycles after reset deassert.
  - A read issued during the sweep produces no predict_v_o.
  - After init, reads of idx 0..15 return predict_o=0, predict_strong_o=0.
- Write idx=3, ghist=0, taken three times, then read idx=3 with GHR forced to 0 via writes:
  - Counter goes 01->10->11->11 (saturates, no wrap).
  - Read returns predict_o=1, predict_strong_o=1.
- Drive writes taken, not-taken, then read idx=5:
  - GHR goes 00 -> 01 -> 10.
  - predict_ghist_o=2'b10.
  - Hashed entry is 5^2=7; verify by pre-training entry 7 to 11 and expecting predict_o=1.
- Same cycle: read idx=4 and write idx=4, ghist=0, taken, with GHR=0:
  - predict_o reflects the old counter (0).
  - Next read of idx=4 with GHR=0 returns predict_o=1.
- Assert reset mid-sweep at ptr=7:
  - All outputs drop to 0 asynchronously.
  - init_done_o rises 16 cycles after the second deassert.
- With BP_FE_BHT_GSHARE_HASH_EN undefined:
  - After training idx=5 to 11, read idx=5 returns predict_o=1 regardless of GHR.
